vga_timing: RTL

Raster timing generator for the VGA unit test. It runs in the `clk_vga` domain produced by the clock block and is held in reset by that block's reset output, inverted to active-low at the top level. It counts pixels and lines of a 640x480@60 Hz frame and emits registered sync, data-enable, pixel coordinates and frame/line markers to the pixel/pattern stage downstream.

---
 rtl/vga_timing.sv | 121 ++++++++++++
 1 files changed

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing
//  Purpose  : Raster timing generator for a 640x480@60 Hz frame. It counts
//             pixels and lines, and emits registered sync, data-enable, pixel
//             coordinates and line/frame start markers for the pixel stage.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i          in   1   pixel clock
//    rst_n_i        in   1   synchronous active-low reset; overrides en_i
//    en_i           in   1   pixel strobe; all state advances only when high
//    hsync_o        out  1   horizontal sync (asserted level = HS_POL)
//    vsync_o        out  1   vertical sync   (asserted level = VS_POL)
//    de_o           out  1   data enable: the current pixel is visible
//    x_o            out  10  pixel column while de_o=1, otherwise 0
//    y_o            out  10  pixel line while de_o=1, otherwise 0
//    line_start_o   out  1   one-strobe pulse at h=0 of every line
//    frame_start_o  out  1   one-strobe pulse at h=0, v=0
// ============================================================================
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       de_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       line_start_o,
    output logic       frame_start_o
);

    // Decode boundaries expressed in counter width. Totals above 1024 are
    // not supported, so every boundary fits in 10 bits.
    localparam logic [9:0] C_H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] C_HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] C_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] C_H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] C_V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] C_VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] C_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] C_V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       de_q, de_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;

    // Counter advance and decode of the current counter values. The outputs
    // register this decode, so they trail the counters by one strobe.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == C_H_LAST) begin
            h_d = 10'd0;
            v_d = (v_q == C_V_LAST) ? 10'd0 : v_q + 10'd1;
        end else begin
            h_d = h_q + 10'd1;
        end

        de_d    = (h_q < C_H_ACT) && (v_q < C_V_ACT);
        hsync_d = ((h_q >= C_HS_BEG) && (h_q < C_HS_END)) ? HS_POL : ~HS_POL;
        // vsync depends on the line only, so it toggles on line boundaries.
        vsync_d = ((v_q >= C_VS_BEG) && (v_q < C_VS_END)) ? VS_POL : ~VS_POL;
        x_d     = de_d ? h_q : 10'd0;
        y_d     = de_d ? v_q : 10'd0;
        ls_d    = (h_q == 10'd0);
        fs_d    = (h_q == 10'd0) && (v_q == 10'd0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else if (en_i) begin
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign line_start_o  = ls_q;
    assign frame_start_o = fs_q;

endmodule
`default_nettype wire
